// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: funct3 encodings, response error codes, FSM states.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_FAULT    = 2'b10,
        ERR_ILLEGAL  = 2'b11
    } err_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_MERGE = 1'b1
    } state_t;

    function automatic logic f3_legal(input logic store, input logic [2:0] f3);
        if (store)
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        else
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                   (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load extract/extend and sub-word store merge.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] load_word,
    input  logic [1:0]  load_offset,
    input  logic [2:0]  load_funct3,
    output logic [31:0] load_data,
    input  logic [31:0] merge_word,
    input  logic [15:0] merge_data,
    input  logic [1:0]  merge_offset,
    input  logic        merge_half,
    output logic [31:0] merged_word
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    always_comb begin
        lane_byte = '0;
        case (load_offset)
            2'd0: lane_byte = load_word[7:0];
            2'd1: lane_byte = load_word[15:8];
            2'd2: lane_byte = load_word[23:16];
            2'd3: lane_byte = load_word[31:24];
            default: lane_byte = '0;
        endcase
        lane_half = load_offset[1] ? load_word[31:16] : load_word[15:0];

        load_data = '0;
        case (load_funct3)
            F3_B:    load_data = {{24{lane_byte[7]}}, lane_byte};
            F3_H:    load_data = {{16{lane_half[15]}}, lane_half};
            F3_W:    load_data = load_word;
            F3_BU:   load_data = {24'd0, lane_byte};
            F3_HU:   load_data = {16'd0, lane_half};
            default: load_data = '0;
        endcase
    end

    always_comb begin
        merged_word = merge_word;
        if (merge_half) begin
            if (merge_offset[1])
                merged_word[31:16] = merge_data;
            else
                merged_word[15:0] = merge_data;
        end else begin
            case (merge_offset)
                2'd0: merged_word[7:0]   = merge_data[7:0];
                2'd1: merged_word[15:8]  = merge_data[7:0];
                2'd2: merged_word[23:16] = merge_data[7:0];
                2'd3: merged_word[31:24] = merge_data[7:0];
                default: merged_word = merge_word;
            endcase
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit over word-only memory; sub-word stores use read-modify-write.
// Optional address bounds checking is enabled with `define LSU_BOUNDS_CHECK_EN.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_store,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic [1:0]            resp_err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_read_en,
    output logic                  mem_write_en,
    output logic [31:0]           mem_write_data,
    input  logic [31:0]           mem_read_data
);

    state_t state, next_state;

    logic                  accept;
    logic                  sub_word;
    logic                  misalign;
    logic                  fault;
    err_t                  req_err;
    logic [31:0]           load_data;
    logic [31:0]           merged_word;

    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [1:0]            lat_off;
    logic                  lat_half;
    logic [15:0]           lat_data;
    logic [31:0]           lat_word;

    assign req_ready = (state == ST_IDLE);
    assign accept    = rst_n & req_valid & req_ready;
    assign sub_word  = (req_funct3[1:0] != 2'b10);
    assign misalign  = ((req_funct3[1:0] == 2'b01) & req_addr[0]) |
                       ((req_funct3[1:0] == 2'b10) & (|req_addr[1:0]));

`ifdef LSU_BOUNDS_CHECK_EN
    assign fault = |req_addr[31:ADDR_WIDTH+2];
`else
    logic unused_hi;
    assign unused_hi = ^req_addr[31:ADDR_WIDTH+2];
    assign fault     = 1'b0;
`endif

    always_comb begin
        if (!f3_legal(req_store, req_funct3))
            req_err = ERR_ILLEGAL;
        else if (misalign)
            req_err = ERR_MISALIGN;
        else if (fault)
            req_err = ERR_FAULT;
        else
            req_err = ERR_NONE;
    end

    // One aligner serves both paths: extract from live read data, merge into the latched word.
    lsu_align u_align (
        .load_word    (mem_read_data),
        .load_offset  (req_addr[1:0]),
        .load_funct3  (req_funct3),
        .load_data    (load_data),
        .merge_word   (lat_word),
        .merge_data   (lat_data),
        .merge_offset (lat_off),
        .merge_half   (lat_half),
        .merged_word  (merged_word)
    );

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state     = state;
        mem_read_en    = 1'b0;
        mem_write_en   = 1'b0;
        mem_addr       = req_addr[ADDR_WIDTH+1:2];
        mem_write_data = req_wdata;
        case (state)
            ST_IDLE: begin
                if (accept && (req_err == ERR_NONE)) begin
                    if (!req_store) begin
                        mem_read_en = 1'b1;
                    end else if (sub_word) begin
                        mem_read_en = 1'b1;
                        next_state  = ST_MERGE;
                    end else begin
                        mem_write_en = 1'b1;
                    end
                end
            end
            ST_MERGE: begin
                mem_write_en   = 1'b1;
                mem_addr       = lat_addr;
                mem_write_data = merged_word;
                next_state     = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
        if (!rst_n) begin
            mem_read_en  = 1'b0;
            mem_write_en = 1'b0;
            next_state   = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lat_addr <= '0;
            lat_off  <= '0;
            lat_half <= 1'b0;
            lat_data <= '0;
            lat_word <= '0;
        end else if (accept && (req_err == ERR_NONE) && req_store && sub_word) begin
            lat_addr <= req_addr[ADDR_WIDTH+1:2];
            lat_off  <= req_addr[1:0];
            lat_half <= req_funct3[0];
            lat_data <= req_wdata[15:0];
            lat_word <= mem_read_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= ERR_NONE;
        end else begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= ERR_NONE;
            if (state == ST_MERGE) begin
                resp_valid <= 1'b1;
            end else if (accept) begin
                if (req_err != ERR_NONE) begin
                    resp_valid <= 1'b1;
                    resp_err   <= req_err;
                end else if (!req_store) begin
                    resp_valid <= 1'b1;
                    resp_rdata <= load_data;
                end else if (!sub_word) begin
                    resp_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit against a byte-array memory model.
module tb_load_store_unit;

    localparam int AW    = 8;
    localparam int WORDS = 1 << AW;
    localparam int BYTES = 4 * WORDS;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_store;
    logic [2:0]    req_funct3;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic [1:0]    resp_err;
    logic [AW-1:0] mem_addr;
    logic          mem_read_en;
    logic          mem_write_en;
    logic [31:0]   mem_write_data;
    logic [31:0]   mem_read_data;

    logic [31:0]   mem [WORDS];
    logic [7:0]    ref_mem [BYTES];
    logic          poke_en = 1'b0;
    logic [AW-1:0] poke_addr = '0;
    logic [31:0]   poke_data = '0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_WIDTH(AW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_store      (req_store),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .mem_addr       (mem_addr),
        .mem_read_en    (mem_read_en),
        .mem_write_en   (mem_write_en),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    assign mem_read_data = mem[mem_addr];

    always @(posedge clk) begin
        if (poke_en)
            mem[poke_addr] <= poke_data;
        else if (mem_write_en)
            mem[mem_addr] <= mem_write_data;
    end

    task automatic poke(input int w, input logic [31:0] d);
        @(negedge clk);
        poke_en   = 1'b1;
        poke_addr = w[AW-1:0];
        poke_data = d;
        for (int i = 0; i < 4; i++) ref_mem[4*w+i] = d[8*i +: 8];
        @(posedge clk);
        #1 poke_en = 1'b0;
    endtask

    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] rd, output logic [1:0] er,
                         output int lat, output logic rd_en0, output logic wr_en0,
                         output logic merge_wr, output logic merge_ready);
        @(negedge clk);
        req_store  = st;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        req_valid  = 1'b1;
        #1;
        rd_en0 = mem_read_en;
        wr_en0 = mem_write_en;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = -1;
        rd = 'x;
        er = 'x;
        merge_wr = 1'b0;
        merge_ready = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) begin
                merge_wr    = mem_write_en;
                merge_ready = req_ready;
            end
            if (resp_valid) begin
                lat = c;
                rd  = resp_rdata;
                er  = resp_err;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010;
        req_addr = 32'h10; req_wdata = '0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if ((mem_read_en | mem_write_en) !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_enables: rd=%b wr=%b required 0 0", mem_read_en, mem_write_en);
        end
        n_checks++;
        if ({resp_valid, resp_rdata, resp_err} !== 35'd0) begin
            n_fail++;
            $display("FAIL reset_resp: valid=%b rdata=%h err=%b required 0 0 00", resp_valid, resp_rdata, resp_err);
        end
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b required 1", req_ready);
        end
        req_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_loads;
        logic [31:0] rd; logic [1:0] er; int lat; logic r0, w0, mw, mr;
        logic [31:0] exp_d [5] = '{32'hFFFFFFAA, 32'h000000AA, 32'hFFFF8899, 32'h00008899, 32'h8899AABB};
        logic [2:0]  f3s   [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
        logic [31:0] addrs [5] = '{32'h11, 32'h11, 32'h12, 32'h12, 32'h10};
        poke(4, 32'h8899AABB);
        for (int i = 0; i < 5; i++) begin
            issue(1'b0, f3s[i], addrs[i], 32'h0, rd, er, lat, r0, w0, mw, mr);
            n_checks++;
            if (rd !== exp_d[i] || er !== 2'b00 || lat != 1) begin
                n_fail++;
                $display("FAIL load_%0d: rdata=%h err=%b lat=%0d required %h 00 1", i, rd, er, lat, exp_d[i]);
            end
            n_checks++;
            if (r0 !== 1'b1 || w0 !== 1'b0) begin
                n_fail++;
                $display("FAIL load_en_%0d: rd_en=%b wr_en=%b required 1 0", i, r0, w0);
            end
        end
    endtask

    task automatic test_sub_stores;
        logic [31:0] rd; logic [1:0] er; int lat; logic r0, w0, mw, mr;
        poke(4, 32'h8899AABB);
        issue(1'b1, 3'b000, 32'h12, 32'h123456CC, rd, er, lat, r0, w0, mw, mr);
        n_checks++;
        if (lat != 2 || er !== 2'b00 || rd !== 32'h0) begin
            n_fail++;
            $display("FAIL sb_resp: lat=%0d err=%b rdata=%h required 2 00 0", lat, er, rd);
        end
        n_checks++;
        if (r0 !== 1'b1 || w0 !== 1'b0 || mw !== 1'b1 || mr !== 1'b0) begin
            n_fail++;
            $display("FAIL sb_handshake: rd0=%b wr0=%b merge_wr=%b merge_ready=%b required 1 0 1 0", r0, w0, mw, mr);
        end
        n_checks++;
        if (mem[4] !== 32'h88CCAABB) begin
            n_fail++;
            $display("FAIL sb_mem: word4=%h required 88ccaabb", mem[4]);
        end
    endtask

    task automatic test_back_to_back;
        poke(4, 32'h8899AABB);
        @(negedge clk);
        req_store = 1'b1; req_funct3 = 3'b001; req_addr = 32'h10; req_wdata = 32'hDEAD1234;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_funct3 = 3'b010; req_wdata = 32'hCAFEF00D;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b0 || mem_write_en !== 1'b1 || mem_write_data !== 32'h88991234) begin
            n_fail++;
            $display("FAIL sh_merge: ready=%b wr=%b data=%h required 0 1 88991234", req_ready, mem_write_en, mem_write_data);
        end
        @(negedge clk);
        n_checks++;
        if (resp_valid !== 1'b1 || req_ready !== 1'b1 || mem[4] !== 32'h88991234) begin
            n_fail++;
            $display("FAIL sh_resp: valid=%b ready=%b word4=%h required 1 1 88991234", resp_valid, req_ready, mem[4]);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (resp_valid !== 1'b1 || resp_err !== 2'b00 || mem[4] !== 32'hCAFEF00D) begin
            n_fail++;
            $display("FAIL sw_b2b: valid=%b err=%b word4=%h required 1 00 cafef00d", resp_valid, resp_err, mem[4]);
        end
    endtask

    task automatic test_errors;
        logic [31:0] rd; logic [1:0] er; int lat; logic r0, w0, mw, mr;
        logic        sts   [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [2:0]  f3s   [6] = '{3'b010, 3'b011, 3'b011, 3'b100, 3'b001, 3'b010};
        logic [31:0] addrs [6] = '{32'h13, 32'h12, 32'h13, 32'h10, 32'h11, 32'h401};
        logic [1:0]  exps  [6] = '{2'b01, 2'b11, 2'b11, 2'b11, 2'b01, 2'b01};
        poke(4, 32'h8899AABB);
        poke(0, 32'h13572468);
        for (int i = 0; i < 6; i++) begin
            issue(sts[i], f3s[i], addrs[i], 32'hFFFFFFFF, rd, er, lat, r0, w0, mw, mr);
            n_checks++;
            if (er !== exps[i] || rd !== 32'h0 || lat != 1 || r0 !== 1'b0 || w0 !== 1'b0) begin
                n_fail++;
                $display("FAIL err_%0d: err=%b rdata=%h lat=%0d rd0=%b wr0=%b required %b 0 1 0 0", i, er, rd, lat, r0, w0, exps[i]);
            end
        end
        n_checks++;
        if (mem[4] !== 32'h8899AABB) begin
            n_fail++;
            $display("FAIL err_mem: word4=%h required 8899aabb", mem[4]);
        end
        issue(1'b0, 3'b010, 32'h400, 32'h0, rd, er, lat, r0, w0, mw, mr);
        n_checks++;
`ifdef LSU_BOUNDS_CHECK_EN
        if (er !== 2'b10 || rd !== 32'h0 || r0 !== 1'b0) begin
            n_fail++;
            $display("FAIL bounds: err=%b rdata=%h rd0=%b required 10 0 0", er, rd, r0);
        end
`else
        if (er !== 2'b00 || rd !== 32'h13572468 || r0 !== 1'b1) begin
            n_fail++;
            $display("FAIL alias: err=%b rdata=%h rd0=%b required 00 13572468 1", er, rd, r0);
        end
`endif
    endtask

    task automatic test_reset_merge;
        poke(4, 32'h8899AABB);
        @(negedge clk);
        req_store = 1'b1; req_funct3 = 3'b000; req_addr = 32'h12; req_wdata = 32'h123456CC;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if (mem_write_en !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_merge_wr: wr=%b required 0", mem_write_en);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (resp_valid !== 1'b0 || req_ready !== 1'b1 || mem[4] !== 32'h8899AABB) begin
                n_fail++;
                $display("FAIL rst_merge_%0d: valid=%b ready=%b word4=%h required 0 1 8899aabb", c, resp_valid, req_ready, mem[4]);
            end
        end
    endtask

    task automatic test_random;
        logic [31:0] rd; logic [1:0] er; int lat; logic r0, w0, mw, mr;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] a, wd, exp_d;
        logic [1:0]  exp_e;
        int          size, ba, exp_lat, legal_cnt;
        logic [2:0]  legal_ld [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        for (int w = 0; w < WORDS; w++) poke(w, $urandom);
        legal_cnt = 0;
        for (int n = 0; n < 1000; n++) begin
            st = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0)
                f3 = 3'($urandom_range(0, 7));
            else if (st)
                f3 = 3'($urandom_range(0, 2));
            else
                f3 = legal_ld[$urandom_range(0, 4)];
            a = 32'($urandom_range(0, BYTES - 1));
            if ($urandom_range(0, 3) != 0) a = a & ~32'((1 << f3[1:0]) - 1);
            if ($urandom_range(0, 9) == 0) a = a | ($urandom & 32'hFFFF_FC00);
            wd = $urandom;

            size  = 1 << f3[1:0];
            ba    = int'(a % BYTES);
            exp_d = '0;
            if (st ? (f3 > 3'd2) : (f3 == 3'd3 || f3 > 3'd5))
                exp_e = 2'b11;
            else if ((a % size) != 0)
                exp_e = 2'b01;
`ifdef LSU_BOUNDS_CHECK_EN
            else if (a >= BYTES)
                exp_e = 2'b10;
`endif
            else
                exp_e = 2'b00;
            exp_lat = 1;
            if (exp_e == 2'b00) begin
                legal_cnt++;
                if (st) begin
                    for (int i = 0; i < size; i++) ref_mem[ba+i] = wd[8*i +: 8];
                    if (size < 4) exp_lat = 2;
                end else begin
                    for (int i = 0; i < size; i++) exp_d = exp_d | (32'(ref_mem[ba+i]) << (8*i));
                    if (!f3[2] && size < 4 && exp_d[8*size-1])
                        exp_d = exp_d | ~((32'd1 << (8*size)) - 32'd1);
                end
            end

            issue(st, f3, a, wd, rd, er, lat, r0, w0, mw, mr);
            n_checks++;
            if (er !== exp_e || rd !== exp_d || lat != exp_lat) begin
                n_fail++;
                $display("FAIL rand_%0d st=%b f3=%b a=%h: err=%b rdata=%h lat=%0d required %b %h %0d",
                         n, st, f3, a, er, rd, lat, exp_e, exp_d, exp_lat);
            end
        end
        n_checks++;
        if (legal_cnt < 300) begin
            n_fail++;
            $display("FAIL rand_mix: legal=%0d required >=300", legal_cnt);
        end
        for (int w = 0; w < WORDS; w++) begin
            n_checks++;
            if (mem[w] !== {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]}) begin
                n_fail++;
                $display("FAIL image_%0d: got %h required %h", w, mem[w],
                         {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]});
            end
        end
    endtask

    initial begin
        test_reset();
        test_loads();
        test_sub_stores();
        test_back_to_back();
        test_errors();
        test_reset_merge();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sits between the core's execute stage and the word-addressed data memory, translating RV32I byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests into whole-word memory accesses. Loads use byte-lane extraction with sign or zero extension. Sub-word stores use a two-cycle read-modify-write, because the memory has no byte enables. Misaligned or illegal requests are detected and reported without touching memory.

## Interface
- `ADDR_WIDTH`, default 8: word-address width of the data memory. The byte address uses bits `[ADDR_WIDTH+1:0]`.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept a request.
- `req_store` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32I funct3 (size/unsigned).
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned.
- `resp_valid` out 1: single-cycle completion pulse, no backpressure.
- `resp_rdata` out 32: extended load result; 0 for stores and errors.
- `resp_err` out 2: 00 ok, 01 misaligned, 10 access fault, 11 illegal funct3.
- `mem_addr` out ADDR_WIDTH: word address to memory.
- `mem_read_en` out 1: memory read enable.
- `mem_write_en` out 1: memory write enable.
- `mem_write_data` out 32: full word to write.
- `mem_read_data` in 32: combinational memory read data.

## Operation
- FSM states are IDLE and MERGE. `req_ready` = 1 only in IDLE. A request is accepted on `req_valid & req_ready`.
- Legal funct3 values:
  - loads: 000, 001, 010, 100, 101
  - stores: 000, 001, 010
- Error check priority is illegal > misaligned > access fault.
  - Misaligned: halfword with `addr[0]`≠0; word with `addr[1:0]`≠0.
- An erroring request issues no memory enables. It responds next cycle with `resp_rdata`=0 and the matching `resp_err`.
- Load, on accept cycle:
  - `mem_read_en`=1, `mem_addr`=`req_addr[ADDR_WIDTH+1:2]`.
  - Select the byte/half lane by `addr[1:0]`; sign-extend (LB/LH) or zero-extend (LBU/LHU).
  - Register the result into `resp_rdata`.
- SW, on accept cycle: `mem_write_en`=1, `mem_write_data`=`req_wdata`.
- SB/SH:
  - Accept cycle: `mem_read_en`=1. Latch the word address, lane offset, size and the low 8/16 bits of `req_wdata`, along with `mem_read_data`. Go to MERGE.
  - MERGE: `mem_write_en`=1 with the latched word, target lane replaced and other lanes preserved. Go to IDLE.
- Memory enables are never high outside these cases and are forced 0 while `rst_n`=0.
- Reset values: state IDLE; `resp_valid`=0; `resp_rdata`=0; `resp_err`=00; all enables 0; all latches 0.

## Timing
- Load, SW and error requests accepted in cycle N respond with `resp_valid` at N+1.
- SB/SH accepted in cycle N: read in N, write in N+1, `resp_valid` at N+2. `req_ready`=0 during N+1.
- Back-to-back requests are allowed in IDLE. A new request may be accepted in the same cycle the previous `resp_valid` is high.
- Reset during MERGE: no write is issued, the next state is IDLE, and no response is produced for the aborted store.
- A read in cycle N observes memory contents before any write committed at the end of N.

## Configuration
- `LSU_BOUNDS_CHECK_EN`:
  - Defined: any nonzero `req_addr[31:ADDR_WIDTH+2]` gives `resp_err`=10 with no memory access.
  - Undefined: the upper bits are ignored (addresses alias), and code 10 is never produced.

## Structure
- `lsu_pkg` holds:
  - funct3 localparams: `F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`
  - error-code enum: `ERR_NONE`, `ERR_MISALIGN`, `ERR_FAULT`, `ERR_ILLEGAL`
  - FSM state enum
- Sub-module `lsu_align` is purely combinational and provides lane extract/extend for loads and lane merge for stores. It is instantiated once.

## Test plan
- Memory word 4 = 0x8899AABB. LB addr 0x11 -> `resp_rdata` 0xFFFFFFAA at N+1; LBU addr 0x11 -> 0x000000AA; LH addr 0x12 -> 0xFFFF8899.
- SB addr 0x12, `wdata` 0x123456CC -> `req_ready` low 1 cycle, word 4 becomes 0x88CCAABB, `resp_valid` at N+2.
- SH addr 0x10, `wdata` 0xDEAD1234 -> word 4 becomes 0x88991234; following SW addr 0x10 0xCAFEF00D accepted on the response cycle -> word 4 = 0xCAFEF00D.
- LW addr 0x13 -> `resp_err` 01, no enables. LH funct3 011 -> `resp_err` 11. With `LSU_BOUNDS_CHECK_EN`, LW addr 0x400 (ADDR_WIDTH 8) -> `resp_err` 10.
- Reset asserted in the MERGE cycle of SB -> `mem_write_en` stays 0, memory unchanged, `resp_valid` 0.
- Random mix of 1000 requests against a byte-array model -> every response and the final memory image match.
